// File: rtl/opc6_io_pkg.sv
// Shared constants for the opc6 I/O timer: register map, CTRL bit positions,
// read-FSM states and the register read multiplexer.
package opc6_io_pkg;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_RELOAD   = 3'd1;
    localparam logic [2:0] TMR_COUNT    = 3'd2;
    localparam logic [2:0] TMR_STATUS   = 3'd3;
    localparam logic [2:0] TMR_PRESCALE = 3'd4;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IEN  = 2;
    localparam int unsigned CTRL_ISEL = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } rd_state_t;

    // Unmapped offsets and unused high bits read as zero.
    function automatic logic [15:0] tmr_read(
        input logic [2:0]  off,
        input logic [3:0]  ctrl,
        input logic [15:0] reload,
        input logic [15:0] count,
        input logic        expf,
        input logic [7:0]  prescale
    );
        logic [15:0] r;
        r = '0;
        case (off)
            TMR_CTRL:     r = {12'd0, ctrl};
            TMR_RELOAD:   r = reload;
            TMR_COUNT:    r = count;
            TMR_STATUS:   r = {15'd0, expf};
            TMR_PRESCALE: r = {8'd0, prescale};
            default:      r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/opc6_prescaler.sv
// Programmable divider: pcnt runs 0..div on each enabled cycle, tick on div.
module opc6_prescaler (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       sys_en,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] pcnt;
    logic       at_top;

    assign at_top = (pcnt == div);
    assign tick   = sys_en & en & at_top;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pcnt <= '0;
        end else if (sys_en) begin
            if (!en || at_top) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/opc6_io_timer.sv
// opc6 I/O-space responder: address decode, timer register file, read
// wait-state FSM driving ready, and the active-low interrupt output.
module opc6_io_timer
    import opc6_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFE00,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        sys_en,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        rnw,
    input  logic        vio,
    output logic [15:0] rdata,
    output logic        ready,
    output logic [1:0]  int_b
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);

    rd_state_t   state, state_n;
    logic [3:0]  wcnt;
    logic [15:0] rdata_q;
    logic        ready_c;

    logic [3:0]  ctrl;
    logic [15:0] reload;
    logic [15:0] count;
    logic        expf;
    logic [7:0]  prescale;

    logic        hit, rd_hit, wr;
    logic [2:0]  off;
    logic        wr_ctrl, wr_reload, wr_count, wr_status, wr_prescale;
    logic        tick, en_next, dec_ok, exp_set, irq;

    assign hit    = vio && (address[15:3] == BASE_ADDR[15:3]);
    assign off    = address[2:0];
    assign rd_hit = hit && rnw;
    assign wr     = hit && !rnw && sys_en && (state == ST_IDLE);

    assign wr_ctrl     = wr && (off == TMR_CTRL);
    assign wr_reload   = wr && (off == TMR_RELOAD);
    assign wr_count    = wr && (off == TMR_COUNT);
    assign wr_status   = wr && (off == TMR_STATUS);
    assign wr_prescale = wr && (off == TMR_PRESCALE);

    opc6_prescaler u_prescaler (
        .clk     (clk),
        .reset_b (reset_b),
        .sys_en  (sys_en),
        .en      (ctrl[CTRL_EN]),
        .div     (prescale),
        .tick    (tick)
    );

    // A CTRL write clearing EN on a tick cycle must suppress that decrement.
    assign en_next = wr_ctrl ? wdata[CTRL_EN] : ctrl[CTRL_EN];
    assign dec_ok  = tick && en_next && !wr_count;
    assign exp_set = dec_ok && (count == 16'd1);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ctrl     <= '0;
            reload   <= '0;
            count    <= '0;
            expf     <= 1'b0;
            prescale <= '0;
        end else if (sys_en) begin
            if (wr_ctrl)     ctrl     <= wdata[3:0];
            if (wr_reload)   reload   <= wdata;
            if (wr_prescale) prescale <= wdata[7:0];

            if (wr_count) begin
                count <= wdata;
            end else if (dec_ok) begin
                if (count > 16'd1) begin
                    count <= count - 16'd1;
                end else if (count == 16'd1) begin
                    count <= ctrl[CTRL_AUTO] ? reload : '0;
                end
            end

            expf <= exp_set || (expf && !(wr_status && wdata[0]));
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            rdata_q <= '0;
        end else if (sys_en) begin
            state <= state_n;
            if (state == ST_IDLE && rd_hit) begin
                rdata_q <= tmr_read(off, ctrl, reload, count, expf, prescale);
                wcnt    <= WS_INIT;
            end else if (state == ST_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ready_c = 1'b1;
        case (state)
            ST_IDLE: begin
                if (rd_hit) begin
                    ready_c = 1'b0;
                    state_n = (WAIT_STATES <= 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                ready_c = 1'b0;
                if (wcnt == 4'd1) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // The CPU bus may still show the read while reset is held; never stall then.
    assign ready = ready_c || !reset_b;
    assign rdata = (state == ST_DONE) ? rdata_q : '0;

    assign irq = expf && ctrl[CTRL_IEN];

    always_comb begin
        int_b    = 2'b11;
        int_b[0] = !(irq && !ctrl[CTRL_ISEL]);
        int_b[1] = !(irq && ctrl[CTRL_ISEL]);
    end

endmodule

// File: tb/tb_opc6_io_timer.sv
// Directed bench for opc6_io_timer with WAIT_STATES=3 at base 16'hFE00.
module tb_opc6_io_timer;

    localparam logic [15:0] BASE = 16'hFE00;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        sys_en = 1'b1;
    logic [15:0] address = '0;
    logic [15:0] wdata = '0;
    logic        rnw = 1'b1;
    logic        vio = 1'b0;
    logic [15:0] rdata;
    logic        ready;
    logic [1:0]  int_b;

    int n_checks = 0;
    int n_fail   = 0;

    opc6_io_timer #(.BASE_ADDR(BASE), .WAIT_STATES(3)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .sys_en  (sys_en),
        .address (address),
        .wdata   (wdata),
        .rnw     (rnw),
        .vio     (vio),
        .rdata   (rdata),
        .ready   (ready),
        .int_b   (int_b)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        address = addr;
        wdata   = data;
        rnw     = 1'b0;
        vio     = 1'b1;
        sys_en  = 1'b1;
        step(1);
        vio = 1'b0;
        rnw = 1'b1;
    endtask

    // Runs a read until ready returns high; leaves the FSM in DONE.
    task automatic bus_read(input logic [15:0] addr, input bit rand_en,
                            output logic [15:0] data, output int low);
        int guard;
        address = addr;
        rnw     = 1'b1;
        vio     = 1'b1;
        low     = 0;
        guard   = 0;
        #1;
        while (ready === 1'b0 && guard < 200) begin
            sys_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sys_en) low++;
            guard++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h: ready=%b required 1", addr, ready);
        end
        data = rdata;
    endtask

    task automatic bus_idle();
        vio    = 1'b0;
        sys_en = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int low;
        reset_b = 1'b0;
        step(2);
        n_checks++;
        if (ready !== 1'b1 || rdata !== 16'h0000 || int_b !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rdata=%h int_b=%b required 1 0000 11", ready, rdata, int_b);
        end
        reset_b = 1'b1;
        step(1);
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (low !== 3) begin
            n_fail++;
            $display("FAIL reset_read_wait: low=%0d required 3", low);
        end
        n_checks++;
        if (d !== 16'h0000 || int_b !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_read_data: rdata=%h int_b=%b required 0000 11", d, int_b);
        end
        bus_idle();
        n_checks++;
        if (ready !== 1'b1 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_read_release: ready=%b rdata=%h required 1 0000", ready, rdata);
        end
    endtask

    task automatic test_autoreload();
        logic [15:0] d;
        int low;
        bus_write(BASE | 16'd1, 16'd4);
        bus_write(BASE | 16'd4, 16'd0);
        bus_write(BASE | 16'd0, 16'h0007);
        bus_write(BASE | 16'd2, 16'd2);
        step(1);
        n_checks++;
        if (int_b !== 2'b11) begin
            n_fail++;
            $display("FAIL auto_pre_expiry: int_b=%b required 11", int_b);
        end
        step(1);
        n_checks++;
        if (int_b !== 2'b10) begin
            n_fail++;
            $display("FAIL auto_expiry_irq: int_b=%b required 10", int_b);
        end
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd4) begin
            n_fail++;
            $display("FAIL auto_reloaded_count: rdata=%h required 0004", d);
        end
        bus_idle();
        bus_read(BASE | 16'd3, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd1) begin
            n_fail++;
            $display("FAIL auto_status_set: rdata=%h required 0001", d);
        end
        bus_idle();
        bus_write(BASE | 16'd0, 16'h0004);
        n_checks++;
        if (int_b !== 2'b10) begin
            n_fail++;
            $display("FAIL auto_irq_hold: int_b=%b required 10", int_b);
        end
        bus_write(BASE | 16'd3, 16'd1);
        n_checks++;
        if (int_b !== 2'b11) begin
            n_fail++;
            $display("FAIL auto_irq_clear: int_b=%b required 11", int_b);
        end
        bus_read(BASE | 16'd3, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd0) begin
            n_fail++;
            $display("FAIL auto_status_cleared: rdata=%h required 0000", d);
        end
        bus_idle();
    endtask

    task automatic test_oneshot();
        logic [15:0] d;
        int low;
        bus_write(BASE | 16'd0, 16'h0000);
        bus_write(BASE | 16'd4, 16'd3);
        bus_write(BASE | 16'd3, 16'd1);
        bus_write(BASE | 16'd2, 16'd5);
        bus_write(BASE | 16'd0, 16'h000D);
        step(6);
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd4) begin
            n_fail++;
            $display("FAIL oneshot_mid_count: rdata=%h required 0004", d);
        end
        bus_idle();
        step(9);
        n_checks++;
        if (int_b !== 2'b11) begin
            n_fail++;
            $display("FAIL oneshot_early: int_b=%b required 11 at cycle 19", int_b);
        end
        step(1);
        n_checks++;
        if (int_b !== 2'b01) begin
            n_fail++;
            $display("FAIL oneshot_isel_irq: int_b=%b required 01 at cycle 20", int_b);
        end
        step(10);
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd0) begin
            n_fail++;
            $display("FAIL oneshot_hold_zero: rdata=%h required 0000", d);
        end
        bus_idle();
        bus_read(BASE | 16'd3, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd1) begin
            n_fail++;
            $display("FAIL oneshot_status: rdata=%h required 0001", d);
        end
        bus_idle();
    endtask

    task automatic test_random_sysen();
        logic [15:0] d;
        int low;
        bus_write(BASE | 16'd0, 16'h0000);
        bus_write(BASE | 16'd4, 16'd0);
        bus_write(BASE | 16'd2, 16'h1234);
        bus_write(BASE | 16'd0, 16'h0001);
        for (int r = 0; r < 3; r++) begin
            bus_read(BASE | 16'd2, 1'b1, d, low);
            n_checks++;
            if (low !== 3) begin
                n_fail++;
                $display("FAIL rand_wait_count run %0d: low=%0d required 3", r, low);
            end
            n_checks++;
            if (d !== 16'h1234 - 16'(r * 4)) begin
                n_fail++;
                $display("FAIL rand_data run %0d: rdata=%h required %h", r, d, 16'h1234 - 16'(r * 4));
            end
            sys_en = 1'b0;
            step(2);
            n_checks++;
            if (ready !== 1'b1 || rdata !== d) begin
                n_fail++;
                $display("FAIL rand_done_hold run %0d: ready=%b rdata=%h required 1 %h", r, ready, rdata, d);
            end
            bus_idle();
        end
        bus_write(BASE | 16'd0, 16'h0000);
    endtask

    task automatic test_collisions();
        logic [15:0] d;
        int low;
        bus_write(BASE | 16'd4, 16'd0);
        bus_write(BASE | 16'd0, 16'h0001);
        bus_write(BASE | 16'd2, 16'h0050);
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (d !== 16'h0050) begin
            n_fail++;
            $display("FAIL coll_count_write: rdata=%h required 0050", d);
        end
        bus_idle();
        bus_write(BASE | 16'd3, 16'd1);
        bus_write(BASE | 16'd2, 16'd2);
        step(1);
        bus_write(BASE | 16'd3, 16'd1);
        bus_read(BASE | 16'd3, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd1) begin
            n_fail++;
            $display("FAIL coll_status_set_wins: rdata=%h required 0001", d);
        end
        bus_idle();
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd0) begin
            n_fail++;
            $display("FAIL coll_expired_count: rdata=%h required 0000", d);
        end
        bus_idle();
        bus_write(BASE | 16'd2, 16'd10);
        bus_write(BASE | 16'd0, 16'h0000);
        bus_read(BASE | 16'd2, 1'b0, d, low);
        n_checks++;
        if (d !== 16'd10) begin
            n_fail++;
            $display("FAIL coll_en_clear: rdata=%h required 000a", d);
        end
        bus_idle();
    endtask

    task automatic test_window();
        logic [15:0] d;
        int low;
        bus_write(BASE | 16'd1, 16'hA5A5);
        bus_write(BASE | 16'd4, 16'h0012);
        bus_write(BASE | 16'd0, 16'h0000);
        for (int o = 5; o < 8; o++) bus_write(BASE | 16'(o), 16'hFFFF);
        bus_write(16'hFD01, 16'hFFFF);
        bus_write(16'hFE08, 16'hFFFF);
        address = 16'hFD02;
        rnw = 1'b1;
        vio = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL miss_read: ready=%b rdata=%h required 1 0000", ready, rdata);
        end
        step(1);
        vio = 1'b0;
        address = BASE | 16'd1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL no_vio: ready=%b rdata=%h required 1 0000", ready, rdata);
        end
        bus_read(BASE | 16'd1, 1'b0, d, low);
        n_checks++;
        if (d !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL window_reload_kept: rdata=%h required a5a5", d);
        end
        bus_idle();
        bus_read(BASE | 16'd4, 1'b0, d, low);
        n_checks++;
        if (d !== 16'h0012) begin
            n_fail++;
            $display("FAIL window_prescale_kept: rdata=%h required 0012", d);
        end
        bus_idle();
        bus_read(BASE | 16'd0, 1'b0, d, low);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++;
            $display("FAIL window_ctrl_kept: rdata=%h required 0000", d);
        end
        bus_idle();
        for (int o = 5; o < 8; o++) begin
            bus_read(BASE | 16'(o), 1'b0, d, low);
            n_checks++;
            if (d !== 16'h0000 || low !== 3) begin
                n_fail++;
                $display("FAIL unmapped_read off %0d: rdata=%h low=%0d required 0000 3", o, d, low);
            end
            bus_idle();
        end
        address = BASE | 16'd1;
        rnw = 1'b1;
        vio = 1'b1;
        step(2);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_stall: ready=%b required 0", ready);
        end
        reset_b = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL midread_reset: ready=%b rdata=%h required 1 0000", ready, rdata);
        end
        vio = 1'b0;
        step(1);
        reset_b = 1'b1;
        step(1);
        bus_read(BASE | 16'd1, 1'b0, d, low);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_clears_reload: rdata=%h required 0000", d);
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_autoreload();
        test_oneshot();
        test_random_sysen();
        test_collisions();
        test_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
